// File: rtl/mlp_eval_harness_pkg.sv
// Shared types and helpers for the printed-MLP evaluation harness.
package mlp_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    REPORT
  } state_e;

  localparam int unsigned SETTLE_CYC_DEF = 8;

  // Settle-counter width: $clog2 of the settle time, never narrower than one bit.
  function automatic int unsigned settle_w(input int unsigned cyc);
    return ($clog2(cyc) < 1) ? 1 : $clog2(cyc);
  endfunction

  localparam int unsigned SETTLE_W_DEF = settle_w(SETTLE_CYC_DEF);

  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/mlp_eval_harness_if.sv
// Sample-in / result-out stream bundle of the evaluation harness.
interface mlp_eval_harness_if #(
  parameter int unsigned NUM_A    = 21,
  parameter int unsigned WIDTH_A  = 4,
  parameter int unsigned OUTWIDTH = 2
);
  logic                       s_valid;
  logic                       s_ready;
  logic [NUM_A*WIDTH_A-1:0]   s_feat;
  logic [OUTWIDTH-1:0]        s_label;
  logic                       s_last;
  logic                       r_valid;
  logic                       r_ready;
  logic [OUTWIDTH-1:0]        r_class;
  logic                       r_match;

  modport master (
    output s_valid, s_feat, s_label, s_last, r_ready,
    input  s_ready, r_valid, r_class, r_match
  );

  modport slave (
    input  s_valid, s_feat, s_label, s_last, r_ready,
    output s_ready, r_valid, r_class, r_match
  );
endinterface

// File: rtl/mlp_eval_harness_sat_counter.sv
// Saturating up-counter; a synchronous clear takes priority over increment.
module sat_counter
  import mlp_eval_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = W'(sat_inc(64'(cnt_q), W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/mlp_eval_harness.sv
// Drives labelled samples into a combinational classifier, waits a settle time,
// captures and scores the class, and keeps saturating accuracy counters.
module mlp_eval_harness
  import mlp_eval_pkg::*;
#(
  parameter int unsigned NUM_A      = 21,
  parameter int unsigned WIDTH_A    = 4,
  parameter int unsigned OUTWIDTH   = 2,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mlp_eval_harness_if.slave        s,
  output logic [NUM_A*WIDTH_A-1:0] dut_inp,
  input  logic [OUTWIDTH-1:0]      dut_out,
  input  logic                     clr,
  output logic [CNT_W-1:0]         total_cnt,
  output logic [CNT_W-1:0]         correct_cnt,
  output logic                     done
);
  localparam int unsigned   SW          = settle_w(SETTLE_CYC);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);

  state_e                   state_q, state_d;
  logic [SW-1:0]            cnt_q, cnt_d;
  logic [NUM_A*WIDTH_A-1:0] feat_q, feat_d;
  logic [OUTWIDTH-1:0]      label_q, label_d;
  logic                     last_q, last_d;
  logic [OUTWIDTH-1:0]      class_q, class_d;
  logic                     match_q, match_d;
  logic                     done_q, done_d;
  logic                     inc_total, inc_correct;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    feat_d      = feat_q;
    label_d     = label_q;
    last_d      = last_q;
    class_d     = class_q;
    match_d     = match_q;
    done_d      = done_q;
    inc_total   = 1'b0;
    inc_correct = 1'b0;
    s.s_ready   = 1'b0;
    s.r_valid   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Gated by rst_n so the stream sees "not ready" throughout reset.
        s.s_ready = ~done_q & rst_n;
        if (s.s_valid && !done_q) begin
          feat_d  = s.s_feat;
          label_d = s.s_label;
          last_d  = s.s_last;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          class_d     = dut_out;
          match_d     = (dut_out == label_q);
          inc_total   = 1'b1;
          inc_correct = (dut_out == label_q);
          state_d     = REPORT;
        end else begin
          cnt_d = cnt_q - SW'(1);
        end
      end
      REPORT: begin
        s.r_valid = 1'b1;
        if (s.r_ready) begin
          if (last_q) done_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) done_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      feat_q  <= '0;
      label_q <= '0;
      last_q  <= 1'b0;
      class_q <= '0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      feat_q  <= feat_d;
      label_q <= label_d;
      last_q  <= last_d;
      class_q <= class_d;
      match_q <= match_d;
      done_q  <= done_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_total (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (inc_total),
    .clr_i (clr),
    .cnt_o (total_cnt)
  );

  sat_counter #(.W(CNT_W)) u_correct (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (inc_correct),
    .clr_i (clr),
    .cnt_o (correct_cnt)
  );

  assign dut_inp   = feat_q;
  assign s.r_class = class_q;
  assign s.r_match = match_q;
  assign done      = done_q;
endmodule

// File: doc/mlp_eval_harness.md
Name: mlp_eval_harness

Overview:
- Synthesizable, parametrised evaluation harness for the combinational printed-MLP classifier (`top`).
- Accepts labelled test samples over a valid/ready stream and drives the feature bus to the classifier.
- Waits a programmable settle time (printed logic is slow), captures the class, and compares it with the label.
- Reports per-sample results and keeps saturating total/correct counters. Intended for on-chip or FPGA accuracy checks across datasets of any feature count and width.

Parameters:
- NUM_A, 21, number of input features.
- WIDTH_A, 4, bits per feature.
- OUTWIDTH, 2, classifier output (class index) width.
- SETTLE_CYC, 8, clock cycles between applying features and sampling the class; legal range is 1 or more.
- CNT_W, 16, width of the total and correct counters.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  sample valid.
- s_ready  out  1  harness can accept a sample.
- s_feat  in  NUM_A*WIDTH_A  packed features; feature i occupies bits [(i+1)*WIDTH_A-1 : i*WIDTH_A].
- s_label  in  OUTWIDTH  expected class.
- s_last  in  1  final sample of the dataset.
- dut_inp  out  NUM_A*WIDTH_A  feature bus to the classifier.
- dut_out  in  OUTWIDTH  classifier result.
- r_valid  out  1  result valid.
- r_ready  in  1  result consumer ready.
- r_class  out  OUTWIDTH  captured class.
- r_match  out  1  r_class equals the label.
- clr  in  1  synchronous clear of the counters and done.
- total_cnt  out  CNT_W  samples evaluated.
- correct_cnt  out  CNT_W  samples matched.
- done  out  1  sticky; set after the last sample's result is consumed.

Behaviour:
- Reset (rst_n low, asynchronous): state goes to IDLE. All outputs are 0, including dut_inp, r_*, both counters and done. s_ready is 0 while reset is asserted.
- FSM states are IDLE, SETTLE and REPORT.
- IDLE:
  - s_ready = ~done.
  - On an edge with s_valid & s_ready: latch s_feat into dut_inp, and latch label and last internally.
  - Load the settle counter with SETTLE_CYC-1, then go to SETTLE.
- SETTLE:
  - s_ready is 0. The counter decrements each cycle.
  - On the edge where the counter is 0: r_class <= dut_out and r_match <= (dut_out == label).
  - On that same edge, increment total_cnt, and increment correct_cnt if matched. Then go to REPORT.
- Latency: features are accepted at edge T0 and the class is sampled at edge T0+SETTLE_CYC. r_valid is high from that edge onward.
- REPORT:
  - r_valid = 1. r_class and r_match stay stable until r_valid & r_ready.
  - On the handshake: if the latched last flag is set, done <= 1. Then go to IDLE.
  - In every case r_valid drops on the next cycle, so no back-to-back result can be presented without passing through IDLE.
- dut_inp holds the last accepted features in all states and does not change outside an IDLE accept.
- Throughput: at most one sample per SETTLE_CYC+2 cycles when r_ready is held high.
- Counters saturate at 2^CNT_W-1. correct_cnt is never greater than total_cnt.
- clr (in any state): zeroes both counters and done on the next edge. If clr coincides with a counter-update edge, clr wins and both counters read 0. An in-flight sample still completes its FSM path and produces a result.
- done = 1 blocks new samples (s_ready = 0) until clr.
- s_valid deasserting while s_ready = 0 is legal. Features are captured only on the handshake.
- Reset asserted mid-SETTLE or mid-REPORT aborts the sample. No result is reported and the counters are cleared.

Decomposition:
- Package mlp_eval_pkg holds:
  - the state enum (IDLE, SETTLE, REPORT);
  - a localparam for the settle-counter width, $clog2(SETTLE_CYC) with a minimum of 1;
  - a function for the saturating increment.
- One natural sub-module, sat_counter (width parameter, with inc, clr and clr-priority), instantiated twice for the total and correct counters.

Test Plan:
- Single sample, SETTLE_CYC=8: drive features 1..21 and label 2, with the model returning 2. r_valid rises exactly 8 edges after the accept; r_class=2, r_match=1, total=1, correct=1.
- Mismatch: label 1, model returns 3. r_match=0, total increments to 1, correct stays at 0.
- Backpressure: hold r_ready=0 for 20 cycles in REPORT. r_valid and r_class stay stable, s_ready=0, no second accept, and dut_inp is unchanged.
- Dataset end: 5 samples with s_last on the 5th, then clr. done rises after the 5th result handshake and s_ready stays 0 until clr; after clr, done=0 and counters are 0.
- Saturation, CNT_W=3: 9 matching samples give total=7 and correct=7, held at saturation. clr on the same edge as an update gives both counters 0.
- Reset mid-SETTLE: assert rst_n=0 asynchronously between edges. All outputs go to 0 immediately, and after release the FSM is in IDLE with s_ready=1.
